case_property_monitor: RTL

- Synthesizable multi-channel runtime property checker.
- Each channel reads a per-channel opcode and applies one of several handshake/timing properties to its req/ack/valid/ready/error signals.
- It reports a pass or fail pulse per attempt, plus saturating fail counters and a sticky global fail flag.
- It sits beside bus/handshake logic as an on-chip monitor. It is the hardware counterpart of opcode-selected case properties, generalised to N channels, parametrised windows, and bounded-eventually/throughout modes.

---
 rtl/case_property_monitor_pkg.sv | 37 +++
 rtl/case_property_monitor_if.sv | 29 ++
 rtl/case_property_monitor_channel.sv | 163 ++++++++++++++++
 rtl/case_property_monitor.sv | 72 +++++++
 4 files changed

// File: rtl/case_property_monitor_pkg.sv
// Shared types for the case property monitor: per-channel check modes,
// the channel FSM states and the opcode decode used by every channel.
package case_prop_pkg;

    // Check applied by a channel; the value equals the opcode that selects it.
    typedef enum logic [2:0] {
        IMPLY      = 3'd0,
        HANDSHAKE  = 3'd1,
        NEXT2      = 3'd2,
        WINDOW     = 3'd3,
        THROUGHOUT = 3'd4,
        EVENTUALLY = 3'd5,
        DEFAULT    = 3'd6
    } mode_e;

    // IDLE evaluates single-cycle checks and triggers; WAIT holds an open attempt.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Only the low three opcode bits select a mode; 6 and 7 both mean DEFAULT.
    function automatic mode_e opcode_to_mode(input logic [2:0] op);
        mode_e m;
        case (op)
            3'd0:    m = IMPLY;
            3'd1:    m = HANDSHAKE;
            3'd2:    m = NEXT2;
            3'd3:    m = WINDOW;
            3'd4:    m = THROUGHOUT;
            3'd5:    m = EVENTUALLY;
            default: m = DEFAULT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/case_property_monitor_if.sv
// Bundle of the monitored handshake signals and the monitor's verdict outputs.
// master drives the observed signals (the bus side), slave is the monitor.
interface case_property_monitor_if #(
    parameter int NCH  = 4,
    parameter int OPW  = 3,
    parameter int CNTW = 8
);
    logic [NCH*OPW-1:0]  opcode;
    logic [NCH-1:0]      req;
    logic [NCH-1:0]      ack;
    logic [NCH-1:0]      valid;
    logic [NCH-1:0]      ready;
    logic [NCH-1:0]      error;
    logic [NCH-1:0]      pass;
    logic [NCH-1:0]      fail;
    logic [NCH-1:0]      busy;
    logic [NCH*CNTW-1:0] fail_cnt;
    logic                sticky_fail;

    modport master (
        output opcode, req, ack, valid, ready, error,
        input  pass, fail, busy, fail_cnt, sticky_fail
    );

    modport slave (
        input  opcode, req, ack, valid, ready, error,
        output pass, fail, busy, fail_cnt, sticky_fail
    );
endinterface

// File: rtl/case_property_monitor_channel.sv
// One monitor channel: IDLE/WAIT FSM, elapsed-cycle counter, registered
// pass/fail pulses and a saturating fail counter.
module case_prop_channel
    import case_prop_pkg::*;
#(
    parameter int WMIN = 1,
    parameter int WMAX = 3,
    parameter int MAXW = 10,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  mode_e           mode_in,
    input  logic            req,
    input  logic            ack,
    input  logic            valid,
    input  logic            ready,
    input  logic            error,
    output logic            pass,
    output logic            fail,
    output logic            busy,
    output logic [CNTW-1:0] fail_cnt,
    output logic            fail_next
);
    localparam int KW = $clog2(MAXW + 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_TWO  = KW'(2);
    localparam logic [KW-1:0] K_WMIN = KW'(WMIN);
    localparam logic [KW-1:0] K_WMAX = KW'(WMAX);
    localparam logic [KW-1:0] K_MAXW = KW'(MAXW);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [KW-1:0] k_q, k_d;
    logic          pass_d, fail_d;

    // Next-state and verdict for the cycle being sampled.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;

        case (state_q)
            IDLE: begin
                k_d = '0;
                case (mode_in)
                    IMPLY: begin
                        if (req) begin
                            pass_d = ack;
                            fail_d = !ack;
                        end
                    end
                    HANDSHAKE: begin
                        if (valid) begin
                            pass_d = ready;
                            fail_d = !ready;
                        end
                    end
                    NEXT2, WINDOW, EVENTUALLY: begin
                        if (req) begin
                            state_d = WAIT;
                            mode_d  = mode_in;
                            k_d     = K_ONE;
                        end
                    end
                    THROUGHOUT: begin
                        if (req && valid) begin
                            state_d = WAIT;
                            mode_d  = mode_in;
                            k_d     = K_ONE;
                        end else if (req) begin
                            fail_d = 1'b1;
                        end
                    end
                    default: begin
                        fail_d = error;
                    end
                endcase
            end

            WAIT: begin
                k_d = k_q + K_ONE;
                case (mode_q)
                    NEXT2: begin
                        if (k_q == K_TWO) begin
                            pass_d = ack;
                            fail_d = !ack;
                        end
                    end
                    WINDOW: begin
                        // Early acks (k < WMIN) are simply ignored.
                        if (ack && (k_q >= K_WMIN)) begin
                            pass_d = 1'b1;
                        end else if (k_q == K_WMAX) begin
                            fail_d = 1'b1;
                        end
                    end
                    THROUGHOUT: begin
                        // valid must hold on every WAIT cycle, the ack cycle included.
                        if (!valid) begin
                            fail_d = 1'b1;
                        end else if (ack) begin
                            pass_d = 1'b1;
                        end else if (k_q == K_MAXW) begin
                            fail_d = 1'b1;
                        end
                    end
                    EVENTUALLY: begin
                        if (ready) begin
                            pass_d = 1'b1;
                        end else if (k_q == K_MAXW) begin
                            fail_d = 1'b1;
                        end
                    end
                    default: begin
                        // Single-cycle modes never open an attempt; recover to IDLE.
                        state_d = IDLE;
                    end
                endcase
                if (pass_d || fail_d) begin
                    state_d = IDLE;
                end
                if (state_d == IDLE) begin
                    k_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // State, held mode, counter, verdict pulses and saturating fail count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= IMPLY;
            k_q      <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            fail_cnt <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            pass    <= pass_d;
            fail    <= fail_d;
            if (fail_d && (fail_cnt != {CNTW{1'b1}})) begin
                fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    assign busy      = (state_q == WAIT);
    assign fail_next = fail_d;

endmodule

// File: rtl/case_property_monitor.sv
// Multi-channel runtime property monitor: slices per-channel opcodes,
// instantiates one checker per channel, packs fail counters and keeps
// a sticky global fail flag.
module case_property_monitor
    import case_prop_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int OPW  = 3,
    parameter int WMIN = 1,
    parameter int WMAX = 3,
    parameter int MAXW = 10,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst,
    case_property_monitor_if.slave bus
);
    logic [NCH-1:0]      pass_w;
    logic [NCH-1:0]      fail_w;
    logic [NCH-1:0]      busy_w;
    logic [NCH-1:0]      fail_next_w;
    logic [NCH*CNTW-1:0] cnt_w;
    mode_e               mode_w [NCH];
    logic                sticky_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign mode_w[i] = opcode_to_mode(bus.opcode[i*OPW +: 3]);

        if (OPW > 3) begin : g_hi
            // Opcode bits above bit 2 carry no meaning for the checker.
            logic unused_opcode_hi;
            assign unused_opcode_hi = ^bus.opcode[i*OPW+3 +: OPW-3];
        end

        case_prop_channel #(
            .WMIN (WMIN),
            .WMAX (WMAX),
            .MAXW (MAXW),
            .CNTW (CNTW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .mode_in   (mode_w[i]),
            .req       (bus.req[i]),
            .ack       (bus.ack[i]),
            .valid     (bus.valid[i]),
            .ready     (bus.ready[i]),
            .error     (bus.error[i]),
            .pass      (pass_w[i]),
            .fail      (fail_w[i]),
            .busy      (busy_w[i]),
            .fail_cnt  (cnt_w[i*CNTW +: CNTW]),
            .fail_next (fail_next_w[i])
        );
    end

    // Sticky flag rises on the same edge as the first fail pulse; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (|fail_next_w) begin
            sticky_q <= 1'b1;
        end
    end

    assign bus.pass        = pass_w;
    assign bus.fail        = fail_w;
    assign bus.busy        = busy_w;
    assign bus.fail_cnt    = cnt_w;
    assign bus.sticky_fail = sticky_q;

endmodule
